// File: rtl/iitb_ss_pkg.sv
// rtl/iitb_ss_pkg.sv - shared types and constants for the 2-wide issue pipe
package iitb_ss_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SPLIT = 2'b01,
    STALL = 2'b10
  } hold_state_t;

  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LM  = 4'b0100;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;

  localparam int DEF_INST_W = 32;
  localparam int DEF_PC_W   = 16;

endpackage

// File: rtl/issue_slot_reg.sv
// rtl/issue_slot_reg.sv - one RF/EX slot: payload register plus qualified valid flop
module issue_slot_reg #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         issue_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  logic [W-1:0] data_q;
  logic         valid_q;

  // Payload follows ID/RF every cycle; only the valid bit carries issue meaning.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_i;
      valid_q <= issue_i & ~flush_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/issue_pair_hold_buffer.sv
// rtl/issue_pair_hold_buffer.sv - ID/RF to RF/EX issue register with split issue
// Optional performance counters enabled by IPHB_PERF_CNT_EN.
module issue_pair_hold_buffer
  import iitb_ss_pkg::*;
#(
  parameter int INST_W = DEF_INST_W,
  parameter int PC_W   = DEF_PC_W,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              valid_next1,
  input  logic              valid_next2,
  input  logic              enable,
  input  logic [INST_W-1:0] id_inst1,
  input  logic [INST_W-1:0] id_inst2,
  input  logic [PC_W-1:0]   id_pc,
  input  logic              id_valid1,
  input  logic              id_valid2,
  output logic [INST_W-1:0] ex_inst1,
  output logic [INST_W-1:0] ex_inst2,
  output logic [PC_W-1:0]   ex_pc,
  output logic              ex_valid1,
  output logic              ex_valid2,
  output logic              id_advance,
  output logic [1:0]        hold_state,
  output logic              protocol_err,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  split_pairs
);

  hold_state_t     state_q, state_d;
  logic            perr_q, perr_d;
  logic [PC_W-1:0] pc_q;
  logic            issue1, issue2;

  // In SPLIT slot 1 already left, so its staller grant is ignored.
  assign issue1 = (state_q != SPLIT) & id_valid1 & valid_next1;
  assign issue2 = id_valid2 & valid_next2 & enable;

  always_comb begin
    state_d = state_q;
    perr_d  = 1'b0;
    if (flush) begin
      state_d = RUN;
    end else if (enable) begin
      state_d = RUN;
      if ((state_q == SPLIT) && id_valid2 && !valid_next2) perr_d = 1'b1;
    end else begin
      if (state_q != SPLIT) state_d = (id_valid1 && valid_next1) ? SPLIT : STALL;
      if (id_valid2 && valid_next2) perr_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      perr_q  <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      perr_q  <= perr_d;
      pc_q    <= id_pc;
    end
  end

  issue_slot_reg #(.W(INST_W)) u_slot1 (
    .clock   (clock),
    .reset   (reset),
    .flush_i (flush),
    .issue_i (issue1),
    .data_i  (id_inst1),
    .data_o  (ex_inst1),
    .valid_o (ex_valid1)
  );

  issue_slot_reg #(.W(INST_W)) u_slot2 (
    .clock   (clock),
    .reset   (reset),
    .flush_i (flush),
    .issue_i (issue2),
    .data_i  (id_inst2),
    .data_o  (ex_inst2),
    .valid_o (ex_valid2)
  );

  assign ex_pc        = pc_q;
  assign id_advance   = enable | flush;
  assign hold_state   = state_q;
  assign protocol_err = perr_q;

`ifdef IPHB_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, split_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      split_q <= '0;
    end else begin
      if (!enable && !flush && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (!flush && (state_q != SPLIT) && (state_d == SPLIT) && (split_q != '1))
        split_q <= split_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign split_pairs  = split_q;
`else
  assign stall_cycles = '0;
  assign split_pairs  = '0;
`endif

endmodule

// File: tb/tb_issue_pair_hold_buffer.sv
// tb/tb_issue_pair_hold_buffer.sv - directed vector bench for issue_pair_hold_buffer
module tb_issue_pair_hold_buffer;

  localparam int INST_W = 32;
  localparam int PC_W   = 16;
  localparam int CNT_W  = 16;

  logic              clock = 1'b0;
  logic              reset, flush, valid_next1, valid_next2, enable;
  logic [INST_W-1:0] id_inst1, id_inst2;
  logic [PC_W-1:0]   id_pc;
  logic              id_valid1, id_valid2;
  logic [INST_W-1:0] ex_inst1, ex_inst2;
  logic [PC_W-1:0]   ex_pc;
  logic              ex_valid1, ex_valid2, id_advance, protocol_err;
  logic [1:0]        hold_state;
  logic [CNT_W-1:0]  stall_cycles, split_pairs;

  issue_pair_hold_buffer #(.INST_W(INST_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .valid_next1  (valid_next1),
    .valid_next2  (valid_next2),
    .enable       (enable),
    .id_inst1     (id_inst1),
    .id_inst2     (id_inst2),
    .id_pc        (id_pc),
    .id_valid1    (id_valid1),
    .id_valid2    (id_valid2),
    .ex_inst1     (ex_inst1),
    .ex_inst2     (ex_inst2),
    .ex_pc        (ex_pc),
    .ex_valid1    (ex_valid1),
    .ex_valid2    (ex_valid2),
    .id_advance   (id_advance),
    .hold_state   (hold_state),
    .protocol_err (protocol_err),
    .stall_cycles (stall_cycles),
    .split_pairs  (split_pairs)
  );

  always #5 clock = ~clock;

  localparam logic [1:0] S_RUN = 2'b00, S_SPLIT = 2'b01, S_STALL = 2'b10;

  typedef struct {
    logic        rst, fl, vn1, vn2, en, iv1, iv2;
    logic [15:0] pc;
    logic        ev1, ev2;
    logic [1:0]  st;
    logic        perr;
  } vec_t;

  vec_t vecs[25];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, fl, vn1, vn2, en, iv1, iv2,
                              input logic [15:0] pc, input logic ev1, ev2,
                              input logic [1:0] st, input logic perr);
    vec_t v;
    v.rst = rst; v.fl = fl; v.vn1 = vn1; v.vn2 = vn2; v.en = en;
    v.iv1 = iv1; v.iv2 = iv2; v.pc = pc;
    v.ev1 = ev1; v.ev2 = ev2; v.st = st; v.perr = perr;
    return v;
  endfunction

  initial begin
    logic [CNT_W-1:0]  exp_stall, exp_split;
    logic [1:0]        prev_st;
    logic [INST_W-1:0] e_i1, e_i2;
    logic [PC_W-1:0]   e_pc;

    //               rst fl vn1 vn2 en iv1 iv2 pc       ev1 ev2 state    perr
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, S_RUN,   0);
    vecs[1]  = mk(0, 0, 1, 1, 1, 1, 1, 16'h0010, 1, 1, S_RUN,   0);
    vecs[2]  = mk(0, 0, 1, 0, 0, 1, 1, 16'h0020, 1, 0, S_SPLIT, 0);
    vecs[3]  = mk(0, 0, 0, 1, 1, 1, 1, 16'h0020, 0, 1, S_RUN,   0);
    vecs[4]  = mk(0, 0, 1, 0, 0, 1, 1, 16'h0030, 1, 0, S_SPLIT, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 1, 1, 16'h0030, 0, 0, S_SPLIT, 0);
    vecs[6]  = mk(0, 0, 0, 1, 1, 1, 1, 16'h0030, 0, 1, S_RUN,   0);
    vecs[7]  = mk(0, 0, 1, 0, 0, 1, 1, 16'h0040, 1, 0, S_SPLIT, 0);
    vecs[8]  = mk(0, 0, 1, 0, 0, 1, 1, 16'h0040, 0, 0, S_SPLIT, 0);
    vecs[9]  = mk(0, 0, 0, 1, 1, 1, 1, 16'h0040, 0, 1, S_RUN,   0);
    vecs[10] = mk(0, 0, 0, 0, 0, 1, 1, 16'h0050, 0, 0, S_STALL, 0);
    vecs[11] = mk(0, 0, 1, 1, 1, 1, 1, 16'h0050, 1, 1, S_RUN,   0);
    vecs[12] = mk(0, 0, 1, 0, 0, 1, 1, 16'h0060, 1, 0, S_SPLIT, 0);
    vecs[13] = mk(0, 1, 0, 1, 1, 1, 1, 16'h0060, 0, 0, S_RUN,   0);
    vecs[14] = mk(0, 0, 1, 0, 0, 1, 1, 16'h0070, 1, 0, S_SPLIT, 0);
    vecs[15] = mk(1, 0, 0, 1, 1, 1, 1, 16'h0070, 0, 0, S_RUN,   0);
    vecs[16] = mk(0, 0, 0, 1, 0, 1, 1, 16'h0080, 0, 0, S_STALL, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 1, 1, 16'h0080, 0, 0, S_STALL, 0);
    vecs[18] = mk(0, 0, 1, 1, 1, 1, 1, 16'h0080, 1, 1, S_RUN,   0);
    vecs[19] = mk(0, 0, 1, 0, 0, 1, 1, 16'h0090, 1, 0, S_SPLIT, 0);
    vecs[20] = mk(0, 0, 0, 0, 1, 1, 1, 16'h0090, 0, 0, S_RUN,   1);
    vecs[21] = mk(0, 0, 1, 1, 0, 0, 0, 16'h00A0, 0, 0, S_STALL, 0);
    vecs[22] = mk(0, 0, 1, 1, 1, 0, 0, 16'h00A0, 0, 0, S_RUN,   0);
    vecs[23] = mk(0, 1, 0, 1, 0, 1, 1, 16'h00B0, 0, 0, S_RUN,   0);
    vecs[24] = mk(0, 0, 1, 0, 0, 1, 0, 16'h00C0, 1, 0, S_SPLIT, 0);

    reset = 1'b1; flush = 1'b0; valid_next1 = 1'b0; valid_next2 = 1'b0; enable = 1'b0;
    id_inst1 = '0; id_inst2 = '0; id_pc = '0; id_valid1 = 1'b0; id_valid2 = 1'b0;
    exp_stall = '0; exp_split = '0; prev_st = S_RUN;

    for (int i = 0; i < 25; i++) begin
      reset = vecs[i].rst; flush = vecs[i].fl;
      valid_next1 = vecs[i].vn1; valid_next2 = vecs[i].vn2; enable = vecs[i].en;
      id_valid1 = vecs[i].iv1; id_valid2 = vecs[i].iv2; id_pc = vecs[i].pc;
      id_inst1 = {16'hA1A1, vecs[i].pc};
      id_inst2 = {16'hB2B2, vecs[i].pc};
      #1;
      chk("id_advance", i, 64'(id_advance), 64'(vecs[i].en | vecs[i].fl));

      if (vecs[i].rst) begin
        exp_stall = '0; exp_split = '0;
        e_i1 = '0; e_i2 = '0; e_pc = '0;
      end else begin
        if (!vecs[i].en && !vecs[i].fl) exp_stall = exp_stall + 1'b1;
        if (!vecs[i].fl && prev_st != S_SPLIT && vecs[i].st == S_SPLIT) exp_split = exp_split + 1'b1;
        e_i1 = id_inst1; e_i2 = id_inst2; e_pc = vecs[i].pc;
      end
      prev_st = vecs[i].st;

      @(posedge clock);
      #1;
      chk("ex_valid1", i, 64'(ex_valid1), 64'(vecs[i].ev1));
      chk("ex_valid2", i, 64'(ex_valid2), 64'(vecs[i].ev2));
      chk("hold_state", i, 64'(hold_state), 64'(vecs[i].st));
      chk("protocol_err", i, 64'(protocol_err), 64'(vecs[i].perr));
      chk("ex_pc", i, 64'(ex_pc), 64'(e_pc));
      chk("ex_inst1", i, 64'(ex_inst1), 64'(e_i1));
      chk("ex_inst2", i, 64'(ex_inst2), 64'(e_i2));
`ifdef IPHB_PERF_CNT_EN
      chk("stall_cycles", i, 64'(stall_cycles), 64'(exp_stall));
      chk("split_pairs", i, 64'(split_pairs), 64'(exp_split));
`else
      chk("stall_cycles", i, 64'(stall_cycles), 64'(0));
      chk("split_pairs", i, 64'(split_pairs), 64'(0));
`endif
    end

    // Held SPLIT with repeated illegal slot-2 grants: protocol_err pulses each offending cycle,
    // slot 2 stays suppressed, and the pair finally leaves with enable.
    flush = 1'b0; reset = 1'b0; valid_next1 = 1'b1; valid_next2 = 1'b1; enable = 1'b0;
    id_valid1 = 1'b1; id_valid2 = 1'b1;
    @(posedge clock); #1;
    chk("seq_hold_perr1", 100, 64'(protocol_err), 64'(1));
    chk("seq_hold_state1", 100, 64'(hold_state), 64'(S_SPLIT));
    chk("seq_hold_v1", 100, 64'(ex_valid1), 64'(0));
    @(posedge clock); #1;
    chk("seq_hold_perr2", 101, 64'(protocol_err), 64'(1));
    chk("seq_hold_v2", 101, 64'(ex_valid2), 64'(0));
    valid_next1 = 1'b0; enable = 1'b1;
    @(posedge clock); #1;
    chk("seq_rel_perr", 102, 64'(protocol_err), 64'(0));
    chk("seq_rel_v2", 102, 64'(ex_valid2), 64'(1));
    chk("seq_rel_state", 102, 64'(hold_state), 64'(S_RUN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
